song_sequencer: RTL and testbench
=================================

Name: song_sequencer

Overview:
- Parametrised note-sequencing controller for the music player; generalises the old single-bit "song over" detector.
- Walks a note ROM address by address and holds each note for its ROM-supplied duration, counted in beat ticks.
- Supports pause, restart and repeat. Signals end of song on an all-notes-played condition or a zero-duration end marker.
- Sits between the beat-tick generator, the note/duration ROM, and the tone generator / top-level song_done logic.

Parameters:
- ADDR_W, 5, note address width; song length is at most 2**ADDR_W notes (default 32).
- DUR_W, 6, duration field width, in beat ticks.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- play  input  1  level; 1 = run, 0 = pause (hold position)
- beat  input  1  one-cycle tick, one per duration unit
- restart  input  1  one-cycle pulse; return to note 0 and wait for play
- repeat_en  input  1  1 = loop the song instead of finishing
- duration  input  DUR_W  duration of the note at addr (combinational ROM output); 0 = end marker
- addr  output  ADDR_W  current note ROM address
- new_note  output  1  one-cycle pulse when a note starts sounding
- note_active  output  1  1 while a note is sounding (PLAY state and play=1)
- song_done  output  1  registered; high while in DONE
- remaining  output  DUR_W  beats left in the current note

Behaviour:
- Clocking and reset:
  - All state updates on posedge clk.
  - reset is synchronous and active-high; it dominates every other input.
  - Reset values: state=IDLE, addr=0, remaining=0, new_note=0, song_done=0, note_active=0.
- States: IDLE, LOAD, PLAY, DONE.
- IDLE: play=1 -> LOAD next cycle. Otherwise stay.
- LOAD (exactly one cycle; duration is sampled here):
  - duration==0 (end marker), repeat_en=0 -> DONE.
  - duration==0, repeat_en=1, addr!=0 -> addr<=0, stay in LOAD.
  - duration==0, repeat_en=1, addr==0 -> DONE. An empty song never spins.
  - duration!=0 -> remaining<=duration, new_note<=1 for exactly one cycle, -> PLAY.
- PLAY:
  - play=0 -> pause: remaining, addr and state frozen, and beats are ignored.
  - play=1 and beat=1 and remaining>1 -> remaining<=remaining-1.
  - play=1 and beat=1 and remaining==1 -> remaining<=0, then:
    - addr != 2**ADDR_W-1 -> addr<=addr+1, -> LOAD.
    - addr == 2**ADDR_W-1 and repeat_en=1 -> addr<=0 (wrap), -> LOAD.
    - addr == 2**ADDR_W-1 and repeat_en=0 -> DONE, addr held at max.
- DONE:
  - song_done=1 and remaining=0.
  - Stays in DONE until restart or reset; play and beat are ignored.
- restart (priority below reset, above all else, any state): addr<=0, remaining<=0, song_done<=0, new_note<=0, -> IDLE.
- Note spacing latency: the last beat of note k to new_note of note k+1 is 2 cycles (PLAY->LOAD, then LOAD->PLAY). Beats arriving in LOAD or IDLE are dropped; beat spacing must be >=3 clk.
- song_done and new_note are registered, never combinational from inputs. note_active = (state==PLAY) & play.
- repeat_en is sampled only at the decision points above; changing it mid-note has no immediate effect.

Test Plan:
- Sequence: reset 2 cycles -> all outputs 0, addr=0. Then ROM durations {3,2,0}, play=1, beat every 4 clk -> new_note at addr 0 and addr 1, 3 then 2 beats held, song_done=1 after the 5th beat, addr=2.
- Full length, no marker: ROM with all 32 durations =1, repeat_en=0 -> exactly 32 new_note pulses, song_done=1, addr=31.
- Same ROM as the full-length scenario, repeat_en=1 -> after addr 31, addr wraps to 0 with a new_note pulse and song_done never rises; a zero-marker ROM {2,0} with repeat_en=1 loops addr 0->1->0.
- Pause: play=0 with remaining=2 for 10 beats -> remaining stays 2, addr unchanged, note_active=0. Play=1 resumes and finishes after 2 more beats.
- Restart: pulse during PLAY at addr=5 -> next cycle IDLE, addr=0, remaining=0. Pulse in DONE -> song_done=0 and IDLE.
- Priority: reset and restart asserted together with beat at remaining==1 -> reset values, no addr increment. An all-zero ROM with repeat_en=1 -> DONE within 2 cycles of play.

Source files
------------

// File: rtl/song_sequencer.sv
// Note sequencer: walks the note ROM, holds each note for its ROM duration in
// beat ticks, and flags end of song on a zero-duration marker or after the last address.
module song_sequencer #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DUR_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              beat,
  input  logic              restart,
  input  logic              repeat_en,
  input  logic [DUR_W-1:0]  duration,
  output logic [ADDR_W-1:0] addr,
  output logic              new_note,
  output logic              note_active,
  output logic              song_done,
  output logic [DUR_W-1:0]  remaining
);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [DUR_W-1:0]  DUR_ONE   = DUR_W'(1);

  state_t state;
  logic   end_marker;
  logic   at_first;
  logic   at_last;
  logic   tick;
  logic   last_beat;

  assign end_marker = (duration == '0);
  assign at_first   = (addr == '0);
  assign at_last    = (addr == ADDR_LAST);
  assign tick       = play & beat;
  assign last_beat  = tick & (remaining == DUR_ONE);

  // Sequencer state, address, beat countdown and registered status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      new_note  <= 1'b0;
      song_done <= 1'b0;
    end else if (restart) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      new_note  <= 1'b0;
      song_done <= 1'b0;
    end else begin
      new_note <= 1'b0;
      case (state)
        IDLE: begin
          if (play) state <= LOAD;
        end
        LOAD: begin
          if (!end_marker) begin
            remaining <= duration;
            new_note  <= 1'b1;
            state     <= PLAY;
          end else if (repeat_en && !at_first) begin
            // Loop back and fetch note 0; an empty song falls through to DONE.
            addr <= '0;
          end else begin
            state     <= DONE;
            song_done <= 1'b1;
          end
        end
        PLAY: begin
          if (last_beat) begin
            remaining <= '0;
            if (!at_last) begin
              addr  <= addr + ADDR_ONE;
              state <= LOAD;
            end else if (repeat_en) begin
              addr  <= '0;
              state <= LOAD;
            end else begin
              state     <= DONE;
              song_done <= 1'b1;
            end
          end else if (tick && (remaining > DUR_ONE)) begin
            remaining <= remaining - DUR_ONE;
          end
        end
        DONE: begin
          song_done <= 1'b1;
          remaining <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sounding only while playing and not paused.
  assign note_active = (state == PLAY) & play;

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: directed scenarios with literal
// expectations plus randomized control traffic checked against a note-level model.
module tb_song_sequencer;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DUR_W    = 6;
  localparam int          SONG_LEN = 1 << ADDR_W;

  localparam int MD_IDLE  = 0;
  localparam int MD_FETCH = 1;
  localparam int MD_SOUND = 2;
  localparam int MD_FIN   = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              play = 1'b0;
  logic              beat = 1'b0;
  logic              restart = 1'b0;
  logic              repeat_en = 1'b0;
  logic [DUR_W-1:0]  duration;
  logic [ADDR_W-1:0] addr;
  logic              new_note;
  logic              note_active;
  logic              song_done;
  logic [DUR_W-1:0]  remaining;

  logic [DUR_W-1:0]  rom [SONG_LEN];

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;
  int nn_total = 0;
  int done_cycles = 0;

  // Model state: which note, beats left, what the song is doing.
  int m_mode = MD_IDLE;
  int m_addr = 0;
  int m_rem = 0;
  bit m_newn = 1'b0;
  bit m_done = 1'b0;

  song_sequencer #(.ADDR_W(ADDR_W), .DUR_W(DUR_W)) dut (
    .clk(clk), .reset(reset), .play(play), .beat(beat), .restart(restart),
    .repeat_en(repeat_en), .duration(duration), .addr(addr), .new_note(new_note),
    .note_active(note_active), .song_done(song_done), .remaining(remaining)
  );

  assign duration = rom[addr];

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat_pulse(input int period);
    beat = 1'b1;
    step(1);
    beat = 1'b0;
    step(period - 1);
  endtask

  task automatic fill_all(input int d);
    for (int i = 0; i < SONG_LEN; i++) rom[i] = DUR_W'(d);
  endtask

  task automatic fill_random();
    for (int i = 0; i < SONG_LEN; i++) begin
      if ($urandom_range(0, 19) == 0) rom[i] = '0;
      else rom[i] = DUR_W'($urandom_range(1, 4));
    end
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    step(1);
    restart = 1'b0;
  endtask

  // Note-level reference: a song is a list of durations walked in order.
  always @(posedge clk) begin
    m_newn <= 1'b0;
    if (reset || restart) begin
      m_mode <= MD_IDLE;
      m_addr <= 0;
      m_rem  <= 0;
      m_done <= 1'b0;
    end else if (m_mode == MD_IDLE) begin
      if (play) m_mode <= MD_FETCH;
    end else if (m_mode == MD_FETCH) begin
      if (int'(rom[m_addr]) != 0) begin
        m_rem  <= int'(rom[m_addr]);
        m_newn <= 1'b1;
        m_mode <= MD_SOUND;
      end else if (repeat_en && m_addr != 0) begin
        m_addr <= 0;
      end else begin
        m_mode <= MD_FIN;
        m_done <= 1'b1;
      end
    end else if (m_mode == MD_SOUND && play && beat) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        if (m_addr == SONG_LEN - 1 && !repeat_en) begin
          m_mode <= MD_FIN;
          m_done <= 1'b1;
        end else begin
          m_addr <= (m_addr + 1) % SONG_LEN;
          m_mode <= MD_FETCH;
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus event tallies.
  always @(negedge clk) begin
    if (new_note === 1'b1) nn_total++;
    if (song_done === 1'b1) done_cycles++;
    if (check_en) begin
      chk("addr", longint'(addr), longint'(m_addr));
      chk("remaining", longint'(remaining), longint'(m_rem));
      chk("new_note", longint'(new_note), longint'(m_newn));
      chk("song_done", longint'(song_done), longint'(m_done));
      chk("note_active", longint'(note_active), (m_mode == MD_SOUND && play) ? 1 : 0);
    end
  end

  initial begin
    int nn0;
    int dc0;
    int gap;

    fill_all(0);
    reset = 1'b1;
    step(2);
    check_en = 1'b1;
    chk("rst_addr", longint'(addr), 0);
    chk("rst_remaining", longint'(remaining), 0);
    chk("rst_new_note", longint'(new_note), 0);
    chk("rst_song_done", longint'(song_done), 0);
    chk("rst_note_active", longint'(note_active), 0);

    // Short song ended by a marker: {3,2,0}.
    rom[0] = DUR_W'(3);
    rom[1] = DUR_W'(2);
    rom[2] = DUR_W'(0);
    reset = 1'b0;
    play = 1'b1;
    repeat_en = 1'b0;
    nn0 = nn_total;
    step(3);
    chk("s1_first_remaining", longint'(remaining), 3);
    for (int i = 0; i < 5; i++) beat_pulse(4);
    chk("s1_done", longint'(song_done), 1);
    chk("s1_addr", longint'(addr), 2);
    chk("s1_notes", nn_total - nn0, 2);

    // Full length, no marker, no repeat.
    fill_all(1);
    pulse_restart();
    nn0 = nn_total;
    step(2);
    for (int i = 0; i < 34; i++) beat_pulse(4);
    chk("s2_notes", nn_total - nn0, 32);
    chk("s2_done", longint'(song_done), 1);
    chk("s2_addr", longint'(addr), 31);

    // Full length with repeat: wraps past 31 and never finishes.
    repeat_en = 1'b1;
    pulse_restart();
    nn0 = nn_total;
    dc0 = done_cycles;
    step(2);
    for (int i = 0; i < 40; i++) beat_pulse(4);
    chk("s3_notes", nn_total - nn0, 41);
    chk("s3_addr_wrapped", longint'(addr), 8);
    chk("s3_no_done", done_cycles - dc0, 0);

    // Marker loop {2,0} with repeat.
    fill_all(0);
    rom[0] = DUR_W'(2);
    pulse_restart();
    nn0 = nn_total;
    step(2);
    for (int i = 0; i < 6; i++) beat_pulse(4);
    chk("s3b_notes", nn_total - nn0, 4);
    chk("s3b_addr", longint'(addr), 0);
    chk("s3b_done", longint'(song_done), 0);

    // Pause holds position and countdown.
    repeat_en = 1'b0;
    fill_all(3);
    pulse_restart();
    step(2);
    beat_pulse(4);
    play = 1'b0;
    for (int i = 0; i < 10; i++) beat_pulse(4);
    chk("pause_remaining", longint'(remaining), 2);
    chk("pause_addr", longint'(addr), 0);
    chk("pause_note_active", longint'(note_active), 0);
    play = 1'b1;
    beat_pulse(4);
    beat_pulse(4);
    chk("resume_addr", longint'(addr), 1);
    chk("resume_remaining", longint'(remaining), 3);

    // Restart mid-play at address 5, then restart out of DONE.
    fill_all(1);
    pulse_restart();
    step(2);
    for (int i = 0; i < 5; i++) beat_pulse(4);
    chk("s5_addr_before", longint'(addr), 5);
    pulse_restart();
    chk("s5_addr", longint'(addr), 0);
    chk("s5_remaining", longint'(remaining), 0);
    chk("s5_note_active", longint'(note_active), 0);
    fill_all(0);
    step(2);
    chk("s5_in_done", longint'(song_done), 1);
    pulse_restart();
    chk("s5_done_cleared", longint'(song_done), 0);

    // Reset and restart together with the final beat of a note at address 1.
    fill_all(2);
    step(2);
    for (int i = 0; i < 3; i++) beat_pulse(4);
    chk("s6_pre_remaining", longint'(remaining), 1);
    chk("s6_pre_addr", longint'(addr), 1);
    reset = 1'b1;
    restart = 1'b1;
    beat = 1'b1;
    play = 1'b0;
    step(1);
    reset = 1'b0;
    restart = 1'b0;
    beat = 1'b0;
    chk("s6_addr", longint'(addr), 0);
    chk("s6_remaining", longint'(remaining), 0);
    chk("s6_new_note", longint'(new_note), 0);
    chk("s6_done", longint'(song_done), 0);

    // Empty song with repeat reaches DONE two cycles after play.
    fill_all(0);
    repeat_en = 1'b1;
    play = 1'b1;
    nn0 = nn_total;
    step(2);
    chk("s6_empty_done", longint'(song_done), 1);
    chk("s6_empty_notes", nn_total - nn0, 0);

    // Randomized traffic against the model.
    fill_random();
    pulse_restart();
    gap = 0;
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 599) == 0);
      restart = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 59) == 0) repeat_en = ~repeat_en;
      play = ($urandom_range(0, 7) != 0);
      if (gap == 0) begin
        beat = 1'b1;
        gap = $urandom_range(3, 6);
      end else begin
        beat = 1'b0;
        gap--;
      end
      if (reset || restart) fill_random();
      step(1);
    end
    reset = 1'b0;
    restart = 1'b0;
    beat = 1'b0;
    step(2);
    check_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
